// File: rtl/boot_stream_loader.sv
// Copies ROM_LEN boot ROM bytes into the core download port, then pulses execute_enable/done.
// Latency: max(ROM_LATENCY,1) FETCH cycles + 1 WRITE cycle per byte; EXEC follows the last accepted byte.
// Backpressure: dn_wait holds the WRITE state with all outputs frozen; there is no timeout.
module boot_stream_loader #(
  parameter int                ROM_LEN     = 276,
  parameter int                ADDR_W      = 16,
  parameter int                ROM_LATENCY = 1,
  parameter logic [ADDR_W-1:0] EXEC_ADDR   = '0
) (
  input  logic              clk_sys,
  input  logic              reset_n,
  input  logic              start,
  output logic              busy,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [7:0]        rom_data,
  input  logic              dn_wait,
  output logic              dn_go,
  output logic              dn_wr,
  output logic [ADDR_W-1:0] dn_addr,
  output logic [7:0]        dn_data,
  output logic [ADDR_W-1:0] execute_addr,
  output logic              execute_enable,
  output logic              done
);

  // A zero-latency ROM still gets one FETCH cycle so rom_data is sampled
  // after rom_addr has settled for a whole cycle.
  localparam int                FETCH_CYC = (ROM_LATENCY == 0) ? 1 : ROM_LATENCY;
  localparam logic [2:0]        LAT_LAST  = 3'(FETCH_CYC - 1);
  // ROM_LEN = 2^ADDR_W makes this all-ones, so the counter never wraps.
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(ROM_LEN - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_FETCH,
    S_WRITE,
    S_EXEC
  } state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;       // byte index, shared by ROM and download port
  logic [2:0]          lat_q, lat_d;         // cycles spent in the current FETCH
  logic [7:0]          data_q, data_d;
  logic [ADDR_W-1:0]   exec_addr_q, exec_addr_d;

  // Next-state and datapath updates; everything holds unless a transition fires.
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    lat_d       = lat_q;
    data_d      = data_q;
    exec_addr_d = exec_addr_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_FETCH;
          addr_d  = '0;
          lat_d   = '0;
        end
      end
      S_FETCH: begin
        if (lat_q == LAT_LAST) begin
          data_d  = rom_data;
          lat_d   = '0;
          state_d = S_WRITE;
        end else begin
          lat_d = lat_q + 3'd1;
        end
      end
      S_WRITE: begin
        if (!dn_wait) begin
          if (addr_q == LAST_ADDR) begin
            state_d     = S_EXEC;
            exec_addr_d = EXEC_ADDR;
          end else begin
            addr_d  = addr_q + ADDR_W'(1);
            state_d = S_FETCH;
          end
        end
      end
      S_EXEC: begin
        // start is deliberately ignored here; a new copy needs a start in IDLE.
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers; reset aborts any copy in progress.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      addr_q      <= '0;
      lat_q       <= '0;
      data_q      <= '0;
      exec_addr_q <= '0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      lat_q       <= lat_d;
      data_q      <= data_d;
      exec_addr_q <= exec_addr_d;
    end
  end

  // Outputs decode straight from registered state, so all clear with reset.
  assign busy           = (state_q != S_IDLE);
  assign dn_go          = (state_q == S_FETCH) || (state_q == S_WRITE);
  assign dn_wr          = (state_q == S_WRITE);
  assign execute_enable = (state_q == S_EXEC);
  assign done           = (state_q == S_EXEC);
  assign rom_addr       = addr_q;
  assign dn_addr        = addr_q;
  assign dn_data        = data_q;
  assign execute_addr   = exec_addr_q;

endmodule

// File: tb/tb_boot_stream_loader.sv
// Directed bench for boot_stream_loader: three instances cover the main
// configuration (LEN=4, LAT=1), a zero-latency ROM (LEN=3) and a full
// address-range copy (ADDR_W=1, LEN=2). Cycle n follows rising edge n.
module tb_boot_stream_loader;

  logic clk_sys = 1'b0;
  always #5 clk_sys = ~clk_sys;

  logic reset_n;

  logic        start_a, busy_a, dn_wait_a, dn_go_a, dn_wr_a, exec_en_a, done_a;
  logic [15:0] rom_addr_a, dn_addr_a, exec_addr_a;
  logic [7:0]  rom_data_a, dn_data_a;

  logic        start_b, busy_b, dn_wait_b, dn_go_b, dn_wr_b, exec_en_b, done_b;
  logic [15:0] rom_addr_b, dn_addr_b, exec_addr_b;
  logic [7:0]  rom_data_b, dn_data_b;

  logic        start_c, busy_c, dn_wait_c, dn_go_c, dn_wr_c, exec_en_c, done_c;
  logic [0:0]  rom_addr_c, dn_addr_c, exec_addr_c;
  logic [7:0]  rom_data_c, dn_data_c;

  logic [7:0] rom_a [0:3] = '{8'h11, 8'h22, 8'h33, 8'h44};
  logic [7:0] rom_b [0:3] = '{8'hA1, 8'hB2, 8'hC3, 8'hEE};
  logic [7:0] rom_c [0:1] = '{8'h5A, 8'hA5};

  // Combinational ROMs; out-of-range reads return a marker value.
  always_comb rom_data_a = (rom_addr_a < 16'd4) ? rom_a[rom_addr_a[1:0]] : 8'hEE;
  always_comb rom_data_b = (rom_addr_b < 16'd3) ? rom_b[rom_addr_b[1:0]] : 8'hEE;
  always_comb rom_data_c = rom_c[rom_addr_c];

  boot_stream_loader #(.ROM_LEN(4), .ADDR_W(16), .ROM_LATENCY(1), .EXEC_ADDR(16'h1234)) u_a (
    .clk_sys(clk_sys), .reset_n(reset_n), .start(start_a), .busy(busy_a),
    .rom_addr(rom_addr_a), .rom_data(rom_data_a), .dn_wait(dn_wait_a), .dn_go(dn_go_a),
    .dn_wr(dn_wr_a), .dn_addr(dn_addr_a), .dn_data(dn_data_a), .execute_addr(exec_addr_a),
    .execute_enable(exec_en_a), .done(done_a));

  boot_stream_loader #(.ROM_LEN(3), .ADDR_W(16), .ROM_LATENCY(0), .EXEC_ADDR(16'h00C0)) u_b (
    .clk_sys(clk_sys), .reset_n(reset_n), .start(start_b), .busy(busy_b),
    .rom_addr(rom_addr_b), .rom_data(rom_data_b), .dn_wait(dn_wait_b), .dn_go(dn_go_b),
    .dn_wr(dn_wr_b), .dn_addr(dn_addr_b), .dn_data(dn_data_b), .execute_addr(exec_addr_b),
    .execute_enable(exec_en_b), .done(done_b));

  boot_stream_loader #(.ROM_LEN(2), .ADDR_W(1), .ROM_LATENCY(1), .EXEC_ADDR(1'b1)) u_c (
    .clk_sys(clk_sys), .reset_n(reset_n), .start(start_c), .busy(busy_c),
    .rom_addr(rom_addr_c), .rom_data(rom_data_c), .dn_wait(dn_wait_c), .dn_go(dn_go_c),
    .dn_wr(dn_wr_c), .dn_addr(dn_addr_c), .dn_data(dn_data_c), .execute_addr(exec_addr_c),
    .execute_enable(exec_en_c), .done(done_c));

  int checks;
  int errors;

  // Activity recorded during a run, keyed by relative cycle.
  int wr_c[$], wr_a[$], acc_c[$], acc_addr[$], acc_dat[$], ex_c[$], dn_c[$];
  int go_n, go_first, go_last, busy_n;

  task automatic clear_rec();
    wr_c.delete(); wr_a.delete(); acc_c.delete(); acc_addr.delete(); acc_dat.delete();
    ex_c.delete(); dn_c.delete();
    go_n = 0; go_first = -1; go_last = -1; busy_n = 0;
  endtask

  task automatic rec(input int c, input logic wr, input logic wt, input int a, input int d,
                     input logic ex, input logic dn, input logic go, input logic bz);
    if (wr) begin
      wr_c.push_back(c); wr_a.push_back(a);
      if (!wt) begin acc_c.push_back(c); acc_addr.push_back(a); acc_dat.push_back(d); end
    end
    if (ex) ex_c.push_back(c);
    if (dn) dn_c.push_back(c);
    if (go) begin go_n++; if (go_first < 0) go_first = c; go_last = c; end
    if (bz) busy_n++;
  endtask

  // Drive start (per-cycle mask) and dn_wait (cycles w_lo..w_hi) on one instance, record outputs.
  task automatic run(input int sel, input int ncyc, input logic [63:0] start_mask,
                     input int w_lo, input int w_hi);
    logic st, wt;
    for (int c = 0; c < ncyc; c++) begin
      @(posedge clk_sys); #1;
      st = start_mask[c];
      wt = (c >= w_lo) && (c <= w_hi);
      case (sel)
        0:       begin start_a = st; dn_wait_a = wt; end
        1:       begin start_b = st; dn_wait_b = wt; end
        default: begin start_c = st; dn_wait_c = wt; end
      endcase
      @(negedge clk_sys);
      case (sel)
        0: rec(c, dn_wr_a, dn_wait_a, int'(dn_addr_a), int'(dn_data_a), exec_en_a, done_a, dn_go_a, busy_a);
        1: rec(c, dn_wr_b, dn_wait_b, int'(dn_addr_b), int'(dn_data_b), exec_en_b, done_b, dn_go_b, busy_b);
        default: rec(c, dn_wr_c, dn_wait_c, int'(dn_addr_c), int'(dn_data_c), exec_en_c, done_c, dn_go_c, busy_c);
      endcase
    end
    start_a = 0; start_b = 0; start_c = 0;
    dn_wait_a = 0; dn_wait_b = 0; dn_wait_c = 0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (2) @(posedge clk_sys);
    #1;
    checks++;
    if ({busy_a, dn_go_a, dn_wr_a, exec_en_a, done_a} !== 5'b0) begin
      errors++; $display("FAIL reset_flags: got %b want 00000", {busy_a, dn_go_a, dn_wr_a, exec_en_a, done_a});
    end
    checks++;
    if (rom_addr_a !== 16'h0 || dn_addr_a !== 16'h0 || dn_data_a !== 8'h0) begin
      errors++; $display("FAIL reset_addr_data: got rom_addr=%h dn_addr=%h dn_data=%h want 0", rom_addr_a, dn_addr_a, dn_data_a);
    end
    checks++;
    if (exec_addr_a !== 16'h0 || exec_addr_b !== 16'h0 || exec_addr_c !== 1'b0) begin
      errors++; $display("FAIL reset_exec_addr: got %h %h %h want 0", exec_addr_a, exec_addr_b, exec_addr_c);
    end
    reset_n = 1'b1;
    repeat (3) @(negedge clk_sys);
    checks++;
    if ({busy_a, dn_go_a, dn_wr_a, busy_b, busy_c} !== 5'b0) begin
      errors++; $display("FAIL idle_no_start: got %b want 00000", {busy_a, dn_go_a, dn_wr_a, busy_b, busy_c});
    end
  endtask

  task automatic test_basic();
    int exp_d[4] = '{32'h11, 32'h22, 32'h33, 32'h44};
    clear_rec();
    run(0, 14, 64'h1, 99, 99);
    checks++;
    if (acc_c.size() != 4) begin errors++; $display("FAIL basic_nwrites: got %0d want 4", acc_c.size()); end
    for (int i = 0; i < 4 && i < acc_c.size(); i++) begin
      checks++;
      if (acc_c[i] != 2 + 2 * i || acc_addr[i] != i || acc_dat[i] != exp_d[i]) begin
        errors++; $display("FAIL basic_write%0d: got cyc=%0d addr=%0d data=%h want cyc=%0d addr=%0d data=%h",
                           i, acc_c[i], acc_addr[i], acc_dat[i], 2 + 2 * i, i, exp_d[i]);
      end
    end
    checks++;
    if (ex_c.size() != 1 || ex_c[0] != 9) begin errors++; $display("FAIL basic_exec: got n=%0d first=%0d want one at 9", ex_c.size(), ex_c.size() ? ex_c[0] : -1); end
    checks++;
    if (dn_c.size() != 1 || dn_c[0] != 9) begin errors++; $display("FAIL basic_done: got n=%0d first=%0d want one at 9", dn_c.size(), dn_c.size() ? dn_c[0] : -1); end
    checks++;
    if (go_n != 8 || go_first != 1 || go_last != 8) begin
      errors++; $display("FAIL basic_dn_go: got n=%0d first=%0d last=%0d want 8/1/8", go_n, go_first, go_last);
    end
    checks++;
    if (busy_n != 9) begin errors++; $display("FAIL basic_busy: got %0d cycles want 9", busy_n); end
    checks++;
    if (exec_addr_a !== 16'h1234) begin errors++; $display("FAIL basic_exec_addr: got %h want 1234", exec_addr_a); end
  endtask

  task automatic test_stall();
    int exp_wc[7] = '{2, 4, 5, 6, 7, 9, 11};
    int exp_wa[7] = '{0, 1, 1, 1, 1, 2, 3};
    int exp_ac[4] = '{2, 7, 9, 11};
    int exp_d[4]  = '{32'h11, 32'h22, 32'h33, 32'h44};
    clear_rec();
    run(0, 16, 64'h1, 4, 6);
    checks++;
    if (wr_c.size() != 7) begin errors++; $display("FAIL stall_nwr: got %0d want 7", wr_c.size()); end
    for (int i = 0; i < 7 && i < wr_c.size(); i++) begin
      checks++;
      if (wr_c[i] != exp_wc[i] || wr_a[i] != exp_wa[i]) begin
        errors++; $display("FAIL stall_wr%0d: got cyc=%0d addr=%0d want cyc=%0d addr=%0d", i, wr_c[i], wr_a[i], exp_wc[i], exp_wa[i]);
      end
    end
    checks++;
    if (acc_c.size() != 4) begin errors++; $display("FAIL stall_naccept: got %0d want 4", acc_c.size()); end
    for (int i = 0; i < 4 && i < acc_c.size(); i++) begin
      checks++;
      if (acc_c[i] != exp_ac[i] || acc_addr[i] != i || acc_dat[i] != exp_d[i]) begin
        errors++; $display("FAIL stall_accept%0d: got cyc=%0d addr=%0d data=%h want cyc=%0d addr=%0d data=%h",
                           i, acc_c[i], acc_addr[i], acc_dat[i], exp_ac[i], i, exp_d[i]);
      end
    end
    checks++;
    if (ex_c.size() != 1 || ex_c[0] != 12) begin errors++; $display("FAIL stall_exec: got n=%0d first=%0d want one at 12", ex_c.size(), ex_c.size() ? ex_c[0] : -1); end
  endtask

  task automatic test_back_to_back();
    int exp_ac[8] = '{2, 4, 6, 8, 12, 14, 16, 18};
    int exp_d[4]  = '{32'h11, 32'h22, 32'h33, 32'h44};
    clear_rec();
    run(0, 24, 64'h609, 99, 99);
    checks++;
    if (acc_c.size() != 8) begin errors++; $display("FAIL b2b_nwrites: got %0d want 8", acc_c.size()); end
    for (int i = 0; i < 8 && i < acc_c.size(); i++) begin
      checks++;
      if (acc_c[i] != exp_ac[i] || acc_addr[i] != i % 4 || acc_dat[i] != exp_d[i % 4]) begin
        errors++; $display("FAIL b2b_write%0d: got cyc=%0d addr=%0d data=%h want cyc=%0d addr=%0d data=%h",
                           i, acc_c[i], acc_addr[i], acc_dat[i], exp_ac[i], i % 4, exp_d[i % 4]);
      end
    end
    checks++;
    if (ex_c.size() != 2 || ex_c[0] != 9 || ex_c[1] != 19) begin
      errors++; $display("FAIL b2b_exec: got n=%0d want two at 9 and 19", ex_c.size());
    end
  endtask

  task automatic test_lat0();
    int exp_d[3] = '{32'hA1, 32'hB2, 32'hC3};
    clear_rec();
    run(1, 12, 64'h1, 99, 99);
    checks++;
    if (acc_c.size() != 3) begin errors++; $display("FAIL lat0_nwrites: got %0d want 3", acc_c.size()); end
    for (int i = 0; i < 3 && i < acc_c.size(); i++) begin
      checks++;
      if (acc_c[i] != 2 + 2 * i || acc_addr[i] != i || acc_dat[i] != exp_d[i]) begin
        errors++; $display("FAIL lat0_write%0d: got cyc=%0d addr=%0d data=%h want cyc=%0d addr=%0d data=%h",
                           i, acc_c[i], acc_addr[i], acc_dat[i], 2 + 2 * i, i, exp_d[i]);
      end
    end
    checks++;
    if (ex_c.size() != 1 || ex_c[0] != 7) begin errors++; $display("FAIL lat0_exec: got n=%0d first=%0d want one at 7", ex_c.size(), ex_c.size() ? ex_c[0] : -1); end
    checks++;
    if (exec_addr_b !== 16'h00C0) begin errors++; $display("FAIL lat0_exec_addr: got %h want 00c0", exec_addr_b); end
  endtask

  task automatic test_full_range();
    int exp_d[2] = '{32'h5A, 32'hA5};
    clear_rec();
    run(2, 12, 64'h1, 99, 99);
    checks++;
    if (acc_c.size() != 2) begin errors++; $display("FAIL full_nwrites: got %0d want 2", acc_c.size()); end
    for (int i = 0; i < 2 && i < acc_c.size(); i++) begin
      checks++;
      if (acc_c[i] != 2 + 2 * i || acc_addr[i] != i || acc_dat[i] != exp_d[i]) begin
        errors++; $display("FAIL full_write%0d: got cyc=%0d addr=%0d data=%h want cyc=%0d addr=%0d data=%h",
                           i, acc_c[i], acc_addr[i], acc_dat[i], 2 + 2 * i, i, exp_d[i]);
      end
    end
    checks++;
    if (ex_c.size() != 1 || ex_c[0] != 5) begin errors++; $display("FAIL full_exec: got n=%0d first=%0d want one at 5", ex_c.size(), ex_c.size() ? ex_c[0] : -1); end
    checks++;
    if (exec_addr_c !== 1'b1 || rom_addr_c !== 1'b1) begin
      errors++; $display("FAIL full_final: got exec_addr=%b rom_addr=%b want 1 1", exec_addr_c, rom_addr_c);
    end
  endtask

  task automatic test_reset_abort();
    clear_rec();
    run(0, 6, 64'h1, 99, 99);
    checks++;
    if (acc_c.size() != 2) begin errors++; $display("FAIL abort_prewrites: got %0d want 2", acc_c.size()); end
    @(posedge clk_sys); #1;
    checks++;
    if (dn_wr_a !== 1'b1 || dn_addr_a !== 16'd2 || dn_data_a !== 8'h33) begin
      errors++; $display("FAIL abort_in_write: got wr=%b addr=%h data=%h want 1 0002 33", dn_wr_a, dn_addr_a, dn_data_a);
    end
    reset_n = 1'b0;
    #1;
    checks++;
    if ({busy_a, dn_go_a, dn_wr_a, exec_en_a, done_a} !== 5'b0) begin
      errors++; $display("FAIL abort_flags: got %b want 00000", {busy_a, dn_go_a, dn_wr_a, exec_en_a, done_a});
    end
    checks++;
    if (rom_addr_a !== 16'h0 || dn_addr_a !== 16'h0 || dn_data_a !== 8'h0 || exec_addr_a !== 16'h0) begin
      errors++; $display("FAIL abort_regs: got %h %h %h %h want 0", rom_addr_a, dn_addr_a, dn_data_a, exec_addr_a);
    end
    repeat (2) @(posedge clk_sys);
    #1 reset_n = 1'b1;
    clear_rec();
    run(0, 20, 64'h0, 99, 99);
    checks++;
    if (wr_c.size() != 0 || ex_c.size() != 0 || busy_n != 0 || go_n != 0) begin
      errors++; $display("FAIL abort_no_restart: got wr=%0d exec=%0d busy=%0d go=%0d want 0", wr_c.size(), ex_c.size(), busy_n, go_n);
    end
  endtask

  initial begin
    checks = 0; errors = 0;
    start_a = 0; start_b = 0; start_c = 0;
    dn_wait_a = 0; dn_wait_b = 0; dn_wait_c = 0;
    test_reset();
    test_basic();
    test_stall();
    test_back_to_back();
    test_lat0();
    test_full_range();
    test_reset_abort();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
